// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : requester handshake bundle (req/data/ack for A and B)
// Revision: 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
   parameter int N_BITS = 8
);
   logic              req_a;
   logic              req_b;
   logic [N_BITS-1:0] data_a;
   logic [N_BITS-1:0] data_b;
   logic              ack_a;
   logic              ack_b;

   modport master (
      output req_a, req_b, data_a, data_b,
      input  ack_a, ack_b
   );

   modport slave (
      input  req_a, req_b, data_a, data_b,
      output ack_a, ack_b
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : two-requester round-robin arbiter feeding an 8N1-style UART TX
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int N_BITS    = 8,
   parameter int NUM_TICKS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ticks,
   uart_tx_arbiter_if.slave  bus,
   output logic              tx,
   output logic              tx_busy,
   output logic              grant_id
);

   localparam int TICK_W = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1;
   localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [TICK_W-1:0]   tick_cnt, tick_cnt_nx;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
   logic [N_BITS-1:0]   shift, shift_nx;
   logic                last_grant, last_grant_nx;
   logic                grant_id_nx;
   logic                ack_a_q, ack_b_q, ack_a_nx, ack_b_nx;
   logic                tx_nx, busy_nx;
   logic                winner;
   logic                bit_end;

   assign bus.ack_a = ack_a_q;
   assign bus.ack_b = ack_b_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         state      <= state_nx;
         tick_cnt   <= tick_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         shift      <= shift_nx;
         last_grant <= last_grant_nx;
         grant_id   <= grant_id_nx;
         ack_a_q    <= ack_a_nx;
         ack_b_q    <= ack_b_nx;
         tx         <= tx_nx;
         tx_busy    <= busy_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      tick_cnt_nx   = tick_cnt;
      bit_cnt_nx    = bit_cnt;
      shift_nx      = shift;
      last_grant_nx = last_grant;
      grant_id_nx   = grant_id;
      ack_a_nx      = 1'b0;
      ack_b_nx      = 1'b0;
      winner        = 1'b0;
      bit_end       = ticks && (tick_cnt == TICK_W'(NUM_TICKS - 1));

      case (state)
         IDLE: begin
            if (bus.req_a || bus.req_b) begin
               // Under contention the side not served last wins.
               winner        = (bus.req_a && bus.req_b) ? ~last_grant : bus.req_b;
               state_nx      = START;
               shift_nx      = winner ? bus.data_b : bus.data_a;
               grant_id_nx   = winner;
               last_grant_nx = winner;
               ack_a_nx      = ~winner;
               ack_b_nx      = winner;
               tick_cnt_nx   = '0;
               bit_cnt_nx    = '0;
            end
         end
         START: begin
            if (bit_end) begin
               tick_cnt_nx = '0;
               state_nx    = DATA;
            end else if (ticks) begin
               tick_cnt_nx = tick_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_cnt_nx = '0;
               shift_nx    = shift >> 1;
               if (bit_cnt == BIT_W'(N_BITS - 1)) begin
                  bit_cnt_nx = '0;
                  state_nx   = STOP;
               end else begin
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end else if (ticks) begin
               tick_cnt_nx = tick_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               tick_cnt_nx = '0;
               state_nx    = IDLE;
            end else if (ticks) begin
               tick_cnt_nx = tick_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Line level is derived from the next state so tx itself is a flop.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
      busy_nx = (state_nx != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int N_BITS    = 8;
   localparam int NUM_TICKS = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic ticks = 1'b0;
   logic tx, tx_busy, grant_id;

   int tick_div   = 1;
   int tick_phase = 0;
   int errors     = 0;
   int checks     = 0;

   logic       samp [0:1023];
   int         len, na, nb, gap;
   int         tot_a, tot_b;
   logic       gid;
   logic [1:0] first_ack;
   int         waited;

   uart_tx_arbiter_if #(.N_BITS(N_BITS)) bus ();

   uart_tx_arbiter #(.N_BITS(N_BITS), .NUM_TICKS(NUM_TICKS)) dut (
      .clock    (clock),
      .reset    (reset),
      .ticks    (ticks),
      .bus      (bus),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .grant_id (grant_id)
   );

   initial forever #5 clock = ~clock;

   initial begin
      forever begin
         @(posedge clock);
         #1;
         tick_phase++;
         ticks = ((tick_phase % tick_div) == 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Call at a falling edge; records one whole frame, counting idle cycles before it.
   task automatic capture(input bit drop);
      int w;
      w   = 0;
      len = 0;
      na  = 0;
      nb  = 0;
      gap = 0;
      while (!tx_busy && w < 3000) begin
         if (bus.ack_a) na++;
         if (bus.ack_b) nb++;
         gap++;
         w++;
         @(negedge clock);
      end
      if (!tx_busy) begin
         check("frame_timeout", {31'd0, tx_busy}, 32'd1);
         return;
      end
      gid       = grant_id;
      first_ack = {bus.ack_b, bus.ack_a};
      if (drop) begin
         bus.req_a = 1'b0;
         bus.req_b = 1'b0;
      end
      while (tx_busy && len < 1024) begin
         samp[len] = tx;
         if (bus.ack_a) na++;
         if (bus.ack_b) nb++;
         len++;
         @(negedge clock);
      end
   endtask

   function automatic int wave_err(input logic [7:0] d);
      int   e;
      int   seg;
      logic x;
      e = 0;
      for (int i = 0; i < 160; i++) begin
         seg = i / 16;
         if (seg == 0)      x = 1'b0;
         else if (seg == 9) x = 1'b1;
         else               x = d[seg-1];
         if (i >= len || samp[i] !== x) e++;
      end
      return e;
   endfunction

   function automatic logic [9:0] decode(input int bl);
      logic [9:0] r;
      for (int k = 0; k < 10; k++) r[k] = samp[k*bl + bl/2];
      return r;
   endfunction

   initial begin
      bus.req_a  = 1'b1;
      bus.req_b  = 1'b0;
      bus.data_a = 8'h55;
      bus.data_b = 8'h00;
      reset      = 1'b0;

      // Held in reset with a request pending
      repeat (5) @(negedge clock);
      check("rst_tx",       {31'd0, tx},        32'd1);
      check("rst_busy",     {31'd0, tx_busy},   32'd0);
      check("rst_ack_a",    {31'd0, bus.ack_a}, 32'd0);
      check("rst_ack_b",    {31'd0, bus.ack_b}, 32'd0);
      check("rst_grant_id", {31'd0, grant_id},  32'd0);

      // Single frame 0x55, ticks every cycle
      reset = 1'b1;
      capture(1'b1);
      check("single_ack_a",     na,                 32'd1);
      check("single_ack_b",     nb,                 32'd0);
      check("single_ack_first", {30'd0, first_ack}, 32'd1);
      check("single_gid",       {31'd0, gid},       32'd0);
      check("single_len",       len,                32'd160);
      check("single_wave",      wave_err(8'h55),    32'd0);
      check("single_decode",    {22'd0, decode(16)}, {22'd0, 1'b1, 8'h55, 1'b0});

      // Contention after a fresh reset: A, B, A
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset      = 1'b1;
      @(negedge clock);
      bus.data_a = 8'h0F;
      bus.data_b = 8'hF0;
      bus.req_a  = 1'b1;
      bus.req_b  = 1'b1;
      capture(1'b0);
      check("cont1_gid",  {31'd0, gid},        32'd0);
      check("cont1_acks", na * 16 + nb,        32'd16);
      check("cont1_data", {22'd0, decode(16)}, {22'd0, 1'b1, 8'h0F, 1'b0});
      capture(1'b0);
      check("cont2_gid",  {31'd0, gid},        32'd1);
      check("cont2_acks", na * 16 + nb,        32'd1);
      check("cont2_data", {22'd0, decode(16)}, {22'd0, 1'b1, 8'hF0, 1'b0});
      capture(1'b0);
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      check("cont3_gid",  {31'd0, gid},        32'd0);
      check("cont3_acks", na * 16 + nb,        32'd16);
      check("cont3_data", {22'd0, decode(16)}, {22'd0, 1'b1, 8'h0F, 1'b0});
      repeat (4) @(negedge clock);
      check("no_queue_busy", {31'd0, tx_busy}, 32'd0);

      // Slow ticks: one in four cycles, B payload 0xA3
      tick_div   = 4;
      bus.data_b = 8'hA3;
      bus.req_b  = 1'b1;
      capture(1'b1);
      check("slow_gid",    {31'd0, gid},        32'd1);
      check("slow_ack_b",  nb,                  32'd1);
      check("slow_decode", {22'd0, decode(64)}, {22'd0, 10'b1_1010_0011_0});
      check("slow_len",    {31'd0, (len >= 637 && len <= 640)}, 32'd1);
      tick_div = 1;
      repeat (3) @(negedge clock);

      // Reset during DATA bit 3, then a pending B frame after release
      bus.data_a = 8'hC6;
      bus.req_a  = 1'b1;
      waited     = 0;
      while (!tx_busy && waited < 100) begin
         waited++;
         @(negedge clock);
      end
      check("mid_started", {31'd0, tx_busy}, 32'd1);
      repeat (72) @(negedge clock);
      check("mid_pre_tx", {31'd0, tx}, 32'd0);
      bus.req_a  = 1'b0;
      bus.req_b  = 1'b1;
      bus.data_b = 8'h3A;
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_tx",   {31'd0, tx},                  32'd1);
      check("mid_rst_busy", {31'd0, tx_busy},             32'd0);
      check("mid_rst_acks", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
      repeat (3) @(negedge clock);
      check("mid_rst_hold_tx", {31'd0, tx}, 32'd1);
      reset = 1'b1;
      capture(1'b1);
      check("mid_after_ack_a", na,              32'd0);
      check("mid_after_ack_b", nb,              32'd1);
      check("mid_after_gid",   {31'd0, gid},    32'd1);
      check("mid_after_len",   len,             32'd160);
      check("mid_after_wave",  wave_err(8'h3A), 32'd0);

      // Back-to-back frames from A with req held
      bus.data_a = 8'h3C;
      bus.req_a  = 1'b1;
      tot_a      = 0;
      tot_b      = 0;
      for (int f = 0; f < 3; f++) begin
         capture(1'b0);
         if (f == 2) bus.req_a = 1'b0;
         tot_a += na;
         tot_b += nb;
         if (f > 0) check($sformatf("b2b_gap%0d", f), gap, 32'd1);
         check($sformatf("b2b_wave%0d", f), wave_err(8'h3C), 32'd0);
      end
      check("b2b_ack_a", tot_a, 32'd3);
      check("b2b_ack_b", tot_b, 32'd0);
      repeat (4) @(negedge clock);
      check("b2b_idle_after", {31'd0, tx_busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
